cordic_sched: RTL

Round-robin scheduler that shares one `cordic_mod` instance between `NREQ` angle requesters. It sits directly in front of the `cordic_mod` input and output ports:
- arbitrates and normalises incoming theta values;
- paces issue to the rate the CORDIC output stage can sustain;
- tags each issued angle with its requester id;
- returns every sin/cos result, in issue order, on a single back-pressured result port.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/sched_fifo.sv | 54 +++++
 rtl/cordic_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, result record and theta normaliser for the CORDIC scheduler.
package cordic_pkg;

  localparam int CORDIC_LAT = 20;
  localparam int ANG_W      = 25;
  localparam int DATA_W     = 32;
  localparam int ID_W       = 3;
  localparam logic [ANG_W-1:0] ANG_360 = 25'(360 << 16);

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] sin;
    logic [DATA_W-1:0] cos;
  } cor_res_t;

  // Folds [360, 512) degrees back into [0, 152) with one subtraction; upper bits dropped.
  function automatic logic [DATA_W-1:0] norm_theta(input logic [DATA_W-1:0] theta);
    logic [ANG_W-1:0] t;
    t = theta[ANG_W-1:0];
    if (t[ANG_W-1:16] >= 9'd360) t = t - ANG_360;
    return {{(DATA_W-ANG_W){1'b0}}, t};
  endfunction

endpackage

// File: rtl/sched_fifo.sv
// Synchronous FIFO with flop storage and full/empty flags; data reads as 0 when empty.
module sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH so any depth works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents are only observed through rdata while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cordic_sched.sv
// Round-robin, credit-paced front end sharing one cordic_mod among NREQ requesters.
// Handshakes: a transfer happens in a cycle where valid and ready are both high;
// req_rdy is one-hot (winner only), and res_vld stays high with stable data until res_rdy.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int CREDITS   = 16,
  parameter int ISSUE_GAP = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_vld,
  output logic [NREQ-1:0]           req_rdy,
  input  logic [NREQ*DATA_W-1:0]    req_theta,
  output logic [DATA_W-1:0]         cor_theta,
  output logic                      cor_shake,
  output logic                      cor_rdy,
  input  logic                      cor_vld,
  input  logic [DATA_W-1:0]         cor_sin,
  input  logic [DATA_W-1:0]         cor_cos,
  output logic                      res_vld,
  input  logic                      res_rdy,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [DATA_W-1:0]         res_sin,
  output logic [DATA_W-1:0]         res_cos,
  output logic                      err_orphan
);

  localparam int IW  = $clog2(NREQ);
  localparam int GW  = $clog2(ISSUE_GAP) + 1;
  localparam int CRW = $clog2(CREDITS + 1);
  localparam int RW  = IW + 2 * DATA_W;

  logic [IW-1:0]  last_q;
  logic [IW-1:0]  win;
  logic [IW:0]    cand;
  logic           found;
  logic [GW-1:0]  gap_q;
  logic [CRW-1:0] credit_q;
  logic           issue_ok;
  logic           accept;
  logic           res_pop;
  logic           tag_full;
  logic           tag_empty;
  logic [IW-1:0]  tag_id;
  logic           res_empty;
  logic           res_full;
  logic           res_push;
  logic [RW-1:0]  res_data;

  assign issue_ok = (gap_q == '0) && (credit_q != '0) && !tag_full;
  assign accept   = issue_ok && (req_vld != '0);
  assign req_rdy  = accept ? (NREQ'(1) << win) : '0;
  assign res_vld  = ~res_empty;
  assign res_pop  = res_vld & res_rdy;
  assign res_push = cor_vld & ~tag_empty & ~res_full;
  assign {res_id, res_sin, res_cos} = res_data;

  // Round-robin search starting one past the last granted index.
  always_comb begin
    win   = last_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && req_vld[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  // Issue register, pacing counter and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cor_theta <= '0;
      cor_shake <= 1'b0;
      last_q    <= IW'(NREQ - 1);
      gap_q     <= '0;
    end else begin
      cor_shake <= accept;
      if (accept) begin
        cor_theta <= norm_theta(req_theta[DATA_W*win +: DATA_W]);
        last_q    <= win;
        gap_q     <= GW'(ISSUE_GAP - 1);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

  // Credits: one spent per issue, one returned per consumed result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= CRW'(CREDITS);
    end else begin
      case ({accept, res_pop})
        2'b10:   credit_q <= credit_q - 1'b1;
        2'b01:   credit_q <= credit_q + 1'b1;
        default: credit_q <= credit_q;
      endcase
    end
  end

  // cor_rdy rises the first cycle after reset; err_orphan is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cor_rdy    <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      cor_rdy <= 1'b1;
      if (cor_vld && tag_empty) err_orphan <= 1'b1;
    end
  end

  sched_fifo #(.WIDTH(IW), .DEPTH(CREDITS)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata (win),
    .pop   (cor_vld),
    .rdata (tag_id),
    .full  (tag_full),
    .empty (tag_empty)
  );

  sched_fifo #(.WIDTH(RW), .DEPTH(CREDITS)) u_res_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (res_push),
    .wdata ({tag_id, cor_sin, cor_cos}),
    .pop   (res_pop),
    .rdata (res_data),
    .full  (res_full),
    .empty (res_empty)
  );

endmodule
